// File: rtl/tx_result_encoder.sv
// Encodes an 8-bit result as ASCII (optional prefix, two hex digits, optional CR/LF)
// and feeds it one character per strobe to a UART transmitter, with a one-deep pending slot.
module tx_result_encoder #(
    parameter logic [7:0] PREFIX_CHAR = 8'h3D,
    parameter int         UPPER_HEX   = 1,
    parameter int         SEND_CRLF   = 1,
    parameter int         GAP         = 3
) (
    input  logic       clk,
    input  logic       Gl_rst,
    input  logic [7:0] L2_adder_data,
    input  logic       L2_adder_rdy,
    input  logic       bu_tx_busy,
    output logic [7:0] Gl_tx_data,
    output logic       Gl_tx_data_rdy,
    output logic       enc_busy,
    output logic       enc_overrun,
    input  logic       enc_clr_ovr
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HI, S_LO, S_CR, S_LF} state_t;

    localparam state_t     FIRST_ST = state_t'((PREFIX_CHAR != 8'h00) ? S_PRE : S_HI);
    localparam state_t     LAST_ST  = state_t'((SEND_CRLF != 0) ? S_LF : S_LO);
    localparam logic [3:0] GAP_L    = 4'(GAP);

    state_t     r_state;
    state_t     w_state_nx;
    state_t     w_after;
    logic [7:0] r_active;
    logic [7:0] r_slot;
    logic       r_slot_full;
    logic [3:0] r_gap;
    logic [7:0] w_char;
    logic       w_emit;
    logic       w_leave;
    logic       w_ovr_set;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            hex_char = 8'h30 + {4'h0, n};
        else
            hex_char = ((UPPER_HEX != 0) ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    assign w_emit    = (r_state != S_IDLE) && (r_gap == 4'd0) && !bu_tx_busy;
    assign w_leave   = w_emit && (r_state == LAST_ST);
    // A result arriving on the draining edge takes the slot being vacated.
    assign w_ovr_set = L2_adder_rdy && r_slot_full && !w_leave;
    assign w_after   = state_t'((r_slot_full || L2_adder_rdy) ? FIRST_ST : S_IDLE);
    assign enc_busy  = (r_state != S_IDLE) || r_slot_full;

    always_ff @(posedge clk or posedge Gl_rst) begin
        if (Gl_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_char     = 8'h00;
        case (r_state)
            S_IDLE: if (L2_adder_rdy) w_state_nx = FIRST_ST;
            S_PRE: begin
                w_char = PREFIX_CHAR;
                if (w_emit) w_state_nx = S_HI;
            end
            S_HI: begin
                w_char = hex_char(r_active[7:4]);
                if (w_emit) w_state_nx = S_LO;
            end
            S_LO: begin
                w_char = hex_char(r_active[3:0]);
                if (w_emit) w_state_nx = (SEND_CRLF != 0) ? S_CR : w_after;
            end
            S_CR: begin
                w_char = 8'h0D;
                if (w_emit) w_state_nx = S_LF;
            end
            S_LF: begin
                w_char = 8'h0A;
                if (w_emit) w_state_nx = w_after;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE && L2_adder_rdy) || (w_leave && !r_slot_full && L2_adder_rdy))
            r_active <= L2_adder_data;
        else if (w_leave && r_slot_full)
            r_active <= r_slot;
        if (L2_adder_rdy && r_state != S_IDLE && (r_slot_full ? w_leave : !w_leave))
            r_slot <= L2_adder_data;
    end

    always_ff @(posedge clk or posedge Gl_rst) begin
        if (Gl_rst) begin
            r_slot_full    <= 1'b0;
            r_gap          <= 4'd0;
            Gl_tx_data     <= 8'h00;
            Gl_tx_data_rdy <= 1'b0;
            enc_overrun    <= 1'b0;
        end else begin
            if (w_leave)
                r_slot_full <= r_slot_full && L2_adder_rdy;
            else if (L2_adder_rdy && r_state != S_IDLE)
                r_slot_full <= 1'b1;

            if (w_emit)
                r_gap <= GAP_L;
            else if (r_gap != 4'd0)
                r_gap <= r_gap - 4'd1;

            Gl_tx_data_rdy <= w_emit;
            if (w_emit)
                Gl_tx_data <= w_char;

            if (w_ovr_set)
                enc_overrun <= 1'b1;
            else if (enc_clr_ovr)
                enc_overrun <= 1'b0;
        end
    end

endmodule
